// File: rtl/sdram_pkg.sv
// Shared widths, read-master state encoding and a byte-swap helper for the
// SDRAM frame reader.
package sdram_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } rd_state_t;

  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// Show-ahead pixel FIFO: head word is visible whenever not empty; synchronous
// clear has priority over read and write.
module sdram_rd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Qualify requests against the current fill level.
  always_comb begin
    wr_ok_s = wr_en & ~full;
    rd_ok_s = rd_en & ~empty;
  end

  assign full    = (cnt_r == CNT_W'(DEPTH));
  assign empty   = (cnt_r == {CNT_W{1'b0}});
  assign count   = cnt_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_ok_s, rd_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !clr) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Display-side SDRAM frame read master with credit-based flow control.
// Optional build macro SDRAM_RD_BYTE_SWAP_EN swaps the bytes of each output pixel.
module sdram_frame_reader
  import sdram_pkg::*;
#(
  parameter int                FRAME_PIXELS = 307200,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 24'h000000,
  parameter int                FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_abort,
  output logic [ADDR_W-1:0] avm_addr,
  output logic              avm_read_n,
  input  logic              avs_waitrequest,
  input  logic [DATA_W-1:0] avs_rddata,
  input  logic              avs_rddata_vld,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_vld,
  input  logic              pix_rdy,
  output logic              pix_last,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int OUT_W = $clog2(FIFO_DEPTH + 1);
  localparam int USE_W = OUT_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [USE_W-1:0] DEPTH_U   = USE_W'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] OUT_ZERO  = {OUT_W{1'b0}};

  rd_state_t         state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              read_n_r;
  logic [CNT_W-1:0]  issue_cnt_r;
  logic [CNT_W-1:0]  pop_cnt_r;
  logic [OUT_W-1:0]  out_cnt_r;
  logic              err_r;

  logic              accept_s;
  logic              abort_s;
  logic              rd_ok_s;
  logic              fifo_wr_req_s;
  logic              fifo_wr_s;
  logic              pop_s;
  logic              last_pop_s;
  logic [CNT_W-1:0]  issue_nxt_s;
  logic [USE_W-1:0]  used_nxt_s;
  logic              can_issue_s;
  logic [OUT_W-1:0]  out_nxt_s;
  logic [OUT_W-1:0]  fifo_cnt_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;

  // Handshake decode and credit accounting for the next cycle.
  always_comb begin
    accept_s      = ~read_n_r & ~avs_waitrequest;
    abort_s       = frame_abort & ((state_r == RUN) | (state_r == DRAIN));
    rd_ok_s       = avs_rddata_vld & (out_cnt_r != OUT_ZERO);
    fifo_wr_req_s = rd_ok_s & ((state_r == RUN) | (state_r == DRAIN)) & ~abort_s;
    fifo_wr_s     = fifo_wr_req_s & ~fifo_full_s;
    pop_s         = ~fifo_empty_s & pix_rdy;
    last_pop_s    = pop_s & (pop_cnt_r == LAST_IDX) & (state_r == DRAIN);
    issue_nxt_s   = issue_cnt_r + CNT_W'(accept_s);
    // A slot is reserved from request acceptance until its pixel leaves the FIFO.
    used_nxt_s    = USE_W'(fifo_cnt_s) + USE_W'(out_cnt_r) + USE_W'(accept_s) - USE_W'(pop_s);
    can_issue_s   = (issue_nxt_s < FRAME_CNT) & (used_nxt_s < DEPTH_U);
    case ({accept_s, rd_ok_s})
      2'b10:   out_nxt_s = out_cnt_r + OUT_W'(1);
      2'b01:   out_nxt_s = out_cnt_r - OUT_W'(1);
      default: out_nxt_s = out_cnt_r;
    endcase
  end

  // Read-master FSM, address/counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= BASE_ADDR;
      read_n_r    <= 1'b1;
      issue_cnt_r <= {CNT_W{1'b0}};
      pop_cnt_r   <= {CNT_W{1'b0}};
      out_cnt_r   <= OUT_ZERO;
      err_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r      <= addr_r + ADDR_W'(1);
        issue_cnt_r <= issue_nxt_s;
      end
      out_cnt_r <= out_nxt_s;
      if (pop_s) pop_cnt_r <= pop_cnt_r + CNT_W'(1);
      if ((avs_rddata_vld && (out_cnt_r == OUT_ZERO)) || (fifo_wr_req_s && fifo_full_s))
        err_r <= 1'b1;

      case (state_r)
        IDLE: begin
          read_n_r <= 1'b1;
          if (frame_start) begin
            state_r     <= RUN;
            addr_r      <= BASE_ADDR;
            issue_cnt_r <= {CNT_W{1'b0}};
            pop_cnt_r   <= {CNT_W{1'b0}};
            out_cnt_r   <= OUT_ZERO;
            read_n_r    <= 1'b0;
          end
        end
        RUN: begin
          if (abort_s) begin
            state_r  <= FLUSH;
            read_n_r <= 1'b1;
          end else if (accept_s && (issue_cnt_r == LAST_IDX)) begin
            state_r  <= DRAIN;
            read_n_r <= 1'b1;
          end else if (!read_n_r && avs_waitrequest) begin
            read_n_r <= 1'b0;
          end else begin
            read_n_r <= ~can_issue_s;
          end
        end
        DRAIN: begin
          read_n_r <= 1'b1;
          if (abort_s) state_r <= FLUSH;
          else if (last_pop_s) state_r <= IDLE;
        end
        FLUSH: begin
          read_n_r <= 1'b1;
          if (out_cnt_r == OUT_ZERO) state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          read_n_r <= 1'b1;
        end
      endcase
    end
  end

  sdram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort_s),
    .wr_en   (fifo_wr_s),
    .wr_data (avs_rddata),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .count   (fifo_cnt_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign avm_addr   = addr_r;
  assign avm_read_n = read_n_r;
  assign pix_vld    = ~fifo_empty_s;
  assign pix_last   = ~fifo_empty_s & (pop_cnt_r == LAST_IDX);
  assign frame_done = last_pop_s;
  assign busy       = (state_r != IDLE);
  assign err        = err_r;

`ifdef SDRAM_RD_BYTE_SWAP_EN
  assign pix_data = byte_swap(fifo_head_s);
`else
  assign pix_data = fifo_head_s;
`endif

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Self-checking bench for sdram_frame_reader: randomized SDRAM/consumer model,
// table-driven frame scenarios and hand-written corner sequences.
module tb_sdram_frame_reader;

  localparam int          FP    = 8;
  localparam logic [23:0] BASE  = 24'h000100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, frame_abort;
  logic [23:0] avm_addr;
  logic        avm_read_n;
  logic        avs_waitrequest;
  logic [15:0] avs_rddata;
  logic        avs_rddata_vld;
  logic [15:0] pix_data;
  logic        pix_vld, pix_rdy, pix_last, frame_done, busy, err;

  always #5 clk = ~clk;

  sdram_frame_reader #(
    .FRAME_PIXELS (FP),
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_start     (frame_start),
    .frame_abort     (frame_abort),
    .avm_addr        (avm_addr),
    .avm_read_n      (avm_read_n),
    .avs_waitrequest (avs_waitrequest),
    .avs_rddata      (avs_rddata),
    .avs_rddata_vld  (avs_rddata_vld),
    .pix_data        (pix_data),
    .pix_vld         (pix_vld),
    .pix_rdy         (pix_rdy),
    .pix_last        (pix_last),
    .frame_done      (frame_done),
    .busy            (busy),
    .err             (err)
  );

  typedef struct {
    logic [15:0] d;
    int          due;
  } resp_t;

  typedef struct {
    int          wait_pct;
    int          rdy_pct;
    int          lat_lo;
    int          lat_hi;
    logic [15:0] pat;
    int          stall_at;
    int          stall_len;
    int          exp_issued;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // SDRAM / consumer model state
  resp_t       rq[$];
  int          cyc = 0;
  int          issued = 0;
  int          popped = 0;
  int          done_cnt = 0;
  int          wait_pct = 0, rdy_pct = 100, lat_lo = 2, lat_hi = 2;
  int          stall_at = -1, stall_len = 0, stall_left = 0;
  logic [15:0] pat = 16'h0000;
  bit          start_req = 1'b0, abort_req = 1'b0, spur = 1'b0, flushing = 1'b0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_addr = 24'h0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory holds word address XOR pattern; output optionally byte-swapped.
  function automatic logic [15:0] exp_pix(input int i);
    logic [23:0] a;
    logic [15:0] d;
    a = BASE + 24'(i);
    d = a[15:0] ^ pat;
`ifdef SDRAM_RD_BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic cycle();
    bit    w, acc;
    resp_t r;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      check(avm_read_n == 1'b0, "hold_read_n", avm_read_n, 0);
      check(avm_addr == prev_addr, "hold_addr", avm_addr, prev_addr);
    end
    if (!avm_read_n) check(avm_addr == BASE + 24'(issued), "req_addr", avm_addr, BASE + 24'(issued));
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      avs_rddata_vld = 1'b1;
      avs_rddata     = r.d;
    end else if (spur) begin
      avs_rddata_vld = 1'b1;
      avs_rddata     = 16'hDEAD;
      spur           = 1'b0;
    end else begin
      avs_rddata_vld = 1'b0;
      avs_rddata     = 16'($urandom);
    end
    if (!avm_read_n && issued == stall_at && stall_left > 0) begin
      w = 1'b1;
      stall_left--;
    end else begin
      w = ($urandom_range(0, 99) < wait_pct);
    end
    avs_waitrequest = w;
    acc = !avm_read_n && !w;
    prev_stall = !avm_read_n && w && !abort_req;
    prev_addr  = avm_addr;
    if (acc) begin
      check(issued < FP, "extra_req", issued, FP - 1);
      rq.push_back('{d: avm_addr[15:0] ^ pat, due: cyc + $urandom_range(lat_lo, lat_hi)});
      issued++;
    end
    if (flushing) check(pix_vld == 1'b0, "flush_pix_vld", pix_vld, 0);
    pix_rdy     = ($urandom_range(0, 99) < rdy_pct);
    frame_start = start_req;
    frame_abort = abort_req;
    start_req   = 1'b0;
    abort_req   = 1'b0;
    #1;
    if (pix_vld && pix_rdy) begin
      check(pix_data == exp_pix(popped), "pix_data", pix_data, exp_pix(popped));
      check(pix_last == (popped == FP - 1), "pix_last", pix_last, (popped == FP - 1));
      check(frame_done == (popped == FP - 1), "frame_done", frame_done, (popped == FP - 1));
      if (popped == FP - 1) done_cnt++;
      popped++;
    end else begin
      check(frame_done == 1'b0, "frame_done_idle", frame_done, 0);
    end
  endtask

  task automatic run_frame(input int d0);
    int guard;
    guard = 0;
    while (popped < FP && guard < 3000) begin
      cycle();
      guard++;
    end
    check(guard < 3000, "frame_timeout", guard, 3000);
    cycle();
    check(busy == 1'b0, "busy_after", busy, 0);
    check(done_cnt == d0 + 1, "done_count", done_cnt, d0 + 1);
  endtask

  task automatic begin_frame();
    issued     = 0;
    popped     = 0;
    stall_left = stall_len;
    start_req  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   d0;
    int   guard;
    vecs[0] = '{wait_pct: 0,  rdy_pct: 100, lat_lo: 2, lat_hi: 2, pat: 16'h0000, stall_at: -1, stall_len: 0, exp_issued: FP, exp_err: 1'b0};
    vecs[1] = '{wait_pct: 0,  rdy_pct: 100, lat_lo: 2, lat_hi: 2, pat: 16'h0000, stall_at: 2,  stall_len: 3, exp_issued: FP, exp_err: 1'b0};
    vecs[2] = '{wait_pct: 30, rdy_pct: 60,  lat_lo: 1, lat_hi: 5, pat: 16'h13AB, stall_at: -1, stall_len: 0, exp_issued: FP, exp_err: 1'b0};
    vecs[3] = '{wait_pct: 50, rdy_pct: 30,  lat_lo: 2, lat_hi: 8, pat: 16'h5A5A, stall_at: -1, stall_len: 0, exp_issued: FP, exp_err: 1'b0};
    vecs[4] = '{wait_pct: 10, rdy_pct: 90,  lat_lo: 1, lat_hi: 1, pat: 16'hF00F, stall_at: 5,  stall_len: 2, exp_issued: FP, exp_err: 1'b0};

    rst_n = 1'b0;
    frame_start = 1'b0; frame_abort = 1'b0;
    avs_waitrequest = 1'b0; avs_rddata = 16'h0; avs_rddata_vld = 1'b0;
    pix_rdy = 1'b0;
    #12;
    check(avm_read_n == 1'b1, "rst_read_n", avm_read_n, 1);
    check(avm_addr == BASE, "rst_addr", avm_addr, BASE);
    check(pix_vld == 1'b0, "rst_pix_vld", pix_vld, 0);
    check(pix_last == 1'b0, "rst_pix_last", pix_last, 0);
    check(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(err == 1'b0, "rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Table-driven full frames
    for (int i = 0; i < 5; i++) begin
      wait_pct  = vecs[i].wait_pct;
      rdy_pct   = vecs[i].rdy_pct;
      lat_lo    = vecs[i].lat_lo;
      lat_hi    = vecs[i].lat_hi;
      pat       = vecs[i].pat;
      stall_at  = vecs[i].stall_at;
      stall_len = vecs[i].stall_len;
      d0 = done_cnt;
      begin_frame();
      run_frame(d0);
      check(issued == vecs[i].exp_issued, "vec_issued", issued, vecs[i].exp_issued);
      check(err == vecs[i].exp_err, "vec_err", err, vecs[i].exp_err);
      check(stall_left == 0, "vec_stall_used", stall_left, 0);
    end
    stall_at = -1; stall_len = 0; wait_pct = 0; lat_lo = 2; lat_hi = 2; pat = 16'h0000;

    // Credit limit: consumer stalled, only FIFO_DEPTH requests may be in flight
    rdy_pct = 0;
    d0 = done_cnt;
    begin_frame();
    repeat (30) cycle();
    check(issued == DEPTH, "credit_issued", issued, DEPTH);
    check(avm_read_n == 1'b1, "credit_read_n", avm_read_n, 1);
    check(pix_vld == 1'b1, "credit_pix_vld", pix_vld, 1);
    check(err == 1'b0, "credit_err", err, 0);
    check(busy == 1'b1, "credit_busy", busy, 1);
    rdy_pct = 100;
    run_frame(d0);

    // Abort with requests outstanding, then restart from BASE
    lat_lo = 3; lat_hi = 3;
    d0 = done_cnt;
    begin_frame();
    guard = 0;
    while (issued < 5 && guard < 200) begin
      cycle();
      guard++;
    end
    check(guard < 200, "abort_reach_timeout", guard, 200);
    abort_req = 1'b1;
    cycle();
    flushing = 1'b1;
    cycle();
    check(busy == 1'b1, "flush_busy", busy, 1);
    check(avm_read_n == 1'b1, "flush_read_n", avm_read_n, 1);
    guard = 0;
    while (busy && guard < 200) begin
      cycle();
      guard++;
    end
    check(guard < 200, "flush_timeout", guard, 200);
    check(rq.size() == 0, "flush_early_idle", rq.size(), 0);
    repeat (3) cycle();
    flushing = 1'b0;
    check(done_cnt == d0, "abort_no_done", done_cnt, d0);
    check(err == 1'b0, "abort_err", err, 0);
    lat_lo = 2; lat_hi = 2;
    begin_frame();
    run_frame(d0);

    // Spurious read data in IDLE: dropped, err sticky
    spur = 1'b1;
    cycle();
    cycle();
    check(err == 1'b1, "spur_err", err, 1);
    check(pix_vld == 1'b0, "spur_pix_vld", pix_vld, 0);
    repeat (5) cycle();
    check(err == 1'b1, "spur_err_sticky", err, 1);
    check(busy == 1'b0, "spur_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
